// File: rtl/poly_basemul_ctrl_if.sv
// Bundle of the handshake, memory-read, multiplier and C-write signals of
// the Kyber base-multiplication controller.
interface poly_basemul_ctrl_if;
    logic        start;
    logic        acc_mode;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [6:0]  mem_rd_addr;
    logic [31:0] a_rd_data;
    logic [31:0] b_rd_data;
    logic [31:0] c_rd_data;
    logic [15:0] gamma_rd_data;
    logic [15:0] mul_a0;
    logic [15:0] mul_a1;
    logic [15:0] mul_b0;
    logic [15:0] mul_b1;
    logic [15:0] mul_gamma;
    logic [15:0] mul_c0;
    logic [15:0] mul_c1;
    logic        c_wr_en;
    logic [6:0]  c_wr_addr;
    logic [31:0] c_wr_data;

    // Controller side.
    modport master (
        input  start, acc_mode,
        input  a_rd_data, b_rd_data, c_rd_data, gamma_rd_data,
        input  mul_c0, mul_c1,
        output busy, done, mem_rd_en, mem_rd_addr,
        output mul_a0, mul_a1, mul_b0, mul_b1, mul_gamma,
        output c_wr_en, c_wr_addr, c_wr_data
    );

    // Requester, memories, gamma ROM and multiplier side.
    modport slave (
        output start, acc_mode,
        output a_rd_data, b_rd_data, c_rd_data, gamma_rd_data,
        output mul_c0, mul_c1,
        input  busy, done, mem_rd_en, mem_rd_addr,
        input  mul_a0, mul_a1, mul_b0, mul_b1, mul_gamma,
        input  c_wr_en, c_wr_addr, c_wr_data
    );
endinterface

// File: rtl/poly_basemul_ctrl.sv
// Streams N_PAIRS coefficient pairs through an external base-case multiplier,
// one pair per cycle, writing (or mod-Q accumulating) results into C.
module poly_basemul_ctrl #(
    parameter int Q       = 3329,
    parameter int N_PAIRS = 128
) (
    input logic                 clk,
    input logic                 rst,
    poly_basemul_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [7:0] LAST_IDX = 8'(N_PAIRS - 1);

    state_t      r_state;
    state_t      w_next;
    logic        w_issue;
    logic [7:0]  r_idx;
    logic        r_drain;
    logic        r_acc;
    logic        r_s1_valid;
    logic [6:0]  r_s1_idx;
    logic        r_s2_valid;
    logic [6:0]  r_s2_idx;
    logic [15:0] r_s2_c0;
    logic [15:0] r_s2_c1;
    logic [31:0] r_s2_cold;
    logic [31:0] w_wr_data;

    function automatic logic [15:0] mod_add(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= 17'(Q)) ? 16'(s - 17'(Q)) : s[15:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN: begin
                w_issue = 1'b1;
                if (r_idx == LAST_IDX) w_next = DRAIN;
            end
            DRAIN:   if (r_drain) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The 8-bit index steps past 127 instead of wrapping, so the exit test cannot re-issue 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_drain <= 1'b0;
            r_acc   <= 1'b0;
        end else begin
            r_drain <= (r_state == DRAIN) && !r_drain;
            if (r_state == IDLE && bus.start) begin
                r_idx <= '0;
                r_acc <= bus.acc_mode;
            end else if (r_state == RUN) begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_idx   <= '0;
            r_s2_c0    <= '0;
            r_s2_c1    <= '0;
            r_s2_cold  <= '0;
        end else begin
            r_s1_valid <= w_issue;
            r_s1_idx   <= r_idx[6:0];
            r_s2_valid <= r_s1_valid;
            r_s2_idx   <= r_s1_idx;
            r_s2_c0    <= bus.mul_c0;
            r_s2_c1    <= bus.mul_c1;
            r_s2_cold  <= bus.c_rd_data;
        end
    end

    always_comb begin
        w_wr_data = {r_s2_c1, r_s2_c0};
        if (r_acc)
            w_wr_data = {mod_add(r_s2_cold[31:16], r_s2_c1), mod_add(r_s2_cold[15:0], r_s2_c0)};
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = (r_state == DONE);
    assign bus.mem_rd_en   = w_issue;
    assign bus.mem_rd_addr = w_issue ? r_idx[6:0] : 7'd0;

    // Operands are forced to zero outside stage 1 so reset leaves every output at 0.
    assign bus.mul_a0    = r_s1_valid ? bus.a_rd_data[15:0]  : 16'd0;
    assign bus.mul_a1    = r_s1_valid ? bus.a_rd_data[31:16] : 16'd0;
    assign bus.mul_b0    = r_s1_valid ? bus.b_rd_data[15:0]  : 16'd0;
    assign bus.mul_b1    = r_s1_valid ? bus.b_rd_data[31:16] : 16'd0;
    assign bus.mul_gamma = r_s1_valid ? bus.gamma_rd_data    : 16'd0;

    assign bus.c_wr_en   = r_s2_valid;
    assign bus.c_wr_addr = r_s2_valid ? r_s2_idx  : 7'd0;
    assign bus.c_wr_data = r_s2_valid ? w_wr_data : 32'd0;

endmodule

// File: tb/tb_poly_basemul_ctrl.sv
// Self-checking bench for poly_basemul_ctrl: memory/ROM/multiplier models,
// constant-pattern vector table, random operations and protocol corner cases.
module tb_poly_basemul_ctrl;

    localparam int Q = 3329;
    localparam int N = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    poly_basemul_ctrl_if bus();

    poly_basemul_ctrl #(.Q(Q), .N_PAIRS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] a_co [2*N];
    logic [15:0] b_co [2*N];
    logic [15:0] c_co [2*N];
    logic [15:0] g_rom[N];
    logic [31:0] exp_w[N];

    int n_checks = 0;
    int n_errors = 0;

    // Memories and gamma ROM: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.a_rd_data     <= {a_co[{bus.mem_rd_addr, 1'b1}], a_co[{bus.mem_rd_addr, 1'b0}]};
            bus.b_rd_data     <= {b_co[{bus.mem_rd_addr, 1'b1}], b_co[{bus.mem_rd_addr, 1'b0}]};
            bus.c_rd_data     <= {c_co[{bus.mem_rd_addr, 1'b1}], c_co[{bus.mem_rd_addr, 1'b0}]};
            bus.gamma_rd_data <= g_rom[bus.mem_rd_addr];
        end
    end

    // External combinational base-case multiplier.
    always_comb begin
        longint t;
        t = (longint'(bus.mul_a1) * longint'(bus.mul_b1)) % Q;
        bus.mul_c0 = 16'((longint'(bus.mul_a0) * longint'(bus.mul_b0) + t * longint'(bus.mul_gamma)) % Q);
        bus.mul_c1 = 16'((longint'(bus.mul_a0) * longint'(bus.mul_b1)
                        + longint'(bus.mul_a1) * longint'(bus.mul_b0)) % Q);
    end

    typedef struct {
        bit    acc;
        int    a0, a1, b0, b1, g, o0, o1;
        int    e0, e1;
        string name;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, " ctl"}, {bus.busy, bus.done, bus.mem_rd_en, bus.mem_rd_addr,
                               bus.c_wr_en, bus.c_wr_addr, bus.c_wr_data}, '0);
        check({name, " mul"}, {bus.mul_a0, bus.mul_a1, bus.mul_b0, bus.mul_b1, bus.mul_gamma}, '0);
    endtask

    task automatic fill_const(input vec_t v);
        for (int i = 0; i < N; i++) begin
            a_co[2*i] = 16'(v.a0); a_co[2*i+1] = 16'(v.a1);
            b_co[2*i] = 16'(v.b0); b_co[2*i+1] = 16'(v.b1);
            c_co[2*i] = 16'(v.o0); c_co[2*i+1] = 16'(v.o1);
            g_rom[i]  = 16'(v.g);
            exp_w[i]  = {16'(v.e1), 16'(v.e0)};
        end
    endtask

    // Reference: schoolbook product in Z_q[X]/(X^2 - gamma), optionally added to old C.
    task automatic fill_rand(input bit acc);
        longint a0, a1, b0, b1, g, r0, r1;
        for (int j = 0; j < 2*N; j++) begin
            a_co[j] = 16'($urandom_range(Q-1));
            b_co[j] = 16'($urandom_range(Q-1));
            c_co[j] = 16'($urandom_range(Q-1));
        end
        for (int i = 0; i < N; i++) begin
            g_rom[i] = 16'($urandom_range(Q-1));
            a0 = a_co[2*i]; a1 = a_co[2*i+1];
            b0 = b_co[2*i]; b1 = b_co[2*i+1];
            g  = g_rom[i];
            r0 = (a0*b0 + a1*b1*g) % Q;
            r1 = (a0*b1 + a1*b0) % Q;
            if (acc) begin
                r0 = (r0 + c_co[2*i]) % Q;
                r1 = (r1 + c_co[2*i+1]) % Q;
            end
            exp_w[i] = {16'(r1), 16'(r0)};
        end
    endtask

    // Issues start (sampled at edge 0) and checks every following cycle against
    // the timeline: read k in cycle k+1, write k in cycle k+3, done in N+3.
    task automatic run_op(input bit acc, input int restart_cyc, input int rst_cyc,
                          input int tail, input string tag);
        int last;
        int window;
        last   = (rst_cyc > 0) ? rst_cyc - 1 : N + 3;
        window = (rst_cyc > 0) ? rst_cyc + 20 : N + 3 + tail;
        bus.acc_mode = acc;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.acc_mode = ~acc;
        for (int c = 1; c <= window; c++) begin
            logic [17:0] act_v, exp_v;
            bit rd_e, wr_e, busy_e, done_e;
            if (c == restart_cyc) bus.start = 1'b1;
            if (c == rst_cyc) rst = 1'b1;
            #1;
            busy_e = (c <= last);
            rd_e   = (c <= N) && (c <= last);
            wr_e   = (c >= 3) && (c <= N + 2) && (c <= last);
            done_e = (rst_cyc == 0) && (c == N + 3);
            exp_v  = {busy_e, done_e, rd_e, wr_e, rd_e ? 7'(c-1) : 7'd0, wr_e ? 7'(c-3) : 7'd0};
            act_v  = {bus.busy, bus.done, bus.mem_rd_en, bus.c_wr_en,
                      bus.mem_rd_en ? bus.mem_rd_addr : 7'd0, bus.c_wr_en ? bus.c_wr_addr : 7'd0};
            check($sformatf("%s ctl cyc%0d", tag, c), act_v, exp_v);
            if (wr_e && bus.c_wr_en)
                check($sformatf("%s wdata idx%0d", tag, c-3), bus.c_wr_data, exp_w[c-3]);
            if (c == rst_cyc)
                check_zero($sformatf("%s in_reset", tag));
            @(posedge clk); #1;
            bus.start = 1'b0;
            rst       = 1'b0;
        end
    endtask

    initial begin
        tbl[0] = '{0, 1, 1, 1, 1, 1, 0, 0, 2, 2, "ones"};
        tbl[1] = '{1, 5, 0, 1, 0, 1, 3328, 3328, 4, 3328, "acc_wrap"};
        tbl[2] = '{0, 3328, 3328, 3328, 3328, 3328, 0, 0, 0, 2, "minus_one"};
        tbl[3] = '{0, 2, 3, 4, 5, 7, 0, 0, 113, 22, "small"};
        tbl[4] = '{1, 2, 3, 4, 5, 7, 3300, 3310, 84, 3, "acc_over"};
        tbl[5] = '{1, 2, 3, 4, 5, 7, 3216, 3307, 0, 0, "acc_eq_q"};
        tbl[6] = '{1, 2, 3, 4, 5, 7, 3215, 3306, 3328, 3328, "acc_q_minus1"};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.acc_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_zero("idle");

        // Back-to-back rows: each start lands in the cycle after the previous done.
        for (int i = 0; i < 7; i++) begin
            fill_const(tbl[i]);
            run_op(tbl[i].acc, 0, 0, 0, tbl[i].name);
        end

        fill_rand(1'b1);
        run_op(1'b1, 50, 0, 0, "restart50");
        fill_rand(1'b0);
        run_op(1'b0, 0, 0, 0, "after_done");
        fill_rand(1'b1);
        run_op(1'b1, N + 3, 0, 20, "start_in_done");
        fill_rand(1'b0);
        run_op(1'b0, 0, 60, 0, "reset60");
        fill_rand(1'b1);
        run_op(1'b1, 0, 0, 0, "post_reset");

        for (int k = 0; k < 4; k++) begin
            fill_rand(k[0]);
            run_op(k[0], 0, 0, 5, $sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/poly_basemul_ctrl.md
POLY_BASEMUL_CTRL -- requirements
Module: poly_basemul_ctrl

Interface
REQ-001 SHALL have parameter Q, default 3329, Kyber modulus used for the accumulate reduction.
REQ-002 SHALL have parameter N_PAIRS, default 128, coefficient pairs per polynomial.
REQ-003 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: start  in  1  one-cycle request to multiply one polynomial pair; acc_mode  in  1  sampled with start, 1 = add product into existing C.
REQ-006 SHALL have ports: busy  out  1  operation in progress; done  out  1  one-cycle completion pulse.
REQ-007 SHALL have ports: mem_rd_en  out  1  read strobe shared by A, B, C memories and gamma ROM; mem_rd_addr  out  7  pair index i.
REQ-008 SHALL have ports: a_rd_data, b_rd_data, c_rd_data  in  32 each  {coef[2i+1], coef[2i]}, valid one cycle after mem_rd_en.
REQ-009 SHALL have ports: gamma_rd_data  in  16  zeta^(2*brv7(i)+1) mod Q from ROM, one-cycle latency.
REQ-010 SHALL have ports: mul_a0, mul_a1, mul_b0, mul_b1, mul_gamma  out  16 each  operands to external combinational base-case multiplier; mul_c0, mul_c1  in  16 each  its results, each < Q.
REQ-011 SHALL have ports: c_wr_en  out  1; c_wr_addr  out  7; c_wr_data  out  32  {c1, c0} result write to C memory.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-013 IDLE -> RUN when start=1 sampled; acc_mode latched on the same edge; index counter cleared to 0.
REQ-014 In RUN, each cycle SHALL assert mem_rd_en with mem_rd_addr = index, then increment index; after index N_PAIRS-1 is issued, RUN -> DRAIN.
REQ-015 DRAIN SHALL last exactly 2 cycles, then -> DONE; DONE lasts 1 cycle, asserts done, -> IDLE.
REQ-016 Stage 1 (cycle after read): mul_a0=a_rd_data[15:0], mul_a1=a_rd_data[31:16], mul_b0/b1 likewise from b_rd_data, mul_gamma=gamma_rd_data; mul_c0/c1, c_rd_data and index SHALL be registered at end of this cycle.
REQ-017 Stage 2: c_wr_en=1, c_wr_addr=registered index; if latched acc_mode=0, c_wr_data={mul_c1, mul_c0} as registered.
REQ-018 If acc_mode=1, each half SHALL be s = c_old + c_new (14-bit), output s-Q if s >= Q else s; c_old halves assumed < Q.
REQ-019 Timing: start sampled at edge 0 -> read of index k in cycle k+1, write of index k in cycle k+3, last write cycle 130, done in cycle 131; busy=1 in cycles 1..131.
REQ-020 Throughput SHALL be one pair per cycle with no bubbles; exactly N_PAIRS writes per operation, addresses 0..127 ascending, no repeats.
REQ-021 start while busy=1 SHALL be ignored (no restart, acc_mode unchanged); start in the DONE cycle SHALL also be ignored.
REQ-022 start asserted in the cycle after done (IDLE) SHALL be accepted normally.
REQ-023 Index counter SHALL be 8-bit internally so 127 -> exit detection has no 7-bit wrap to 0 re-issue.
REQ-024 mem_rd_en, c_wr_en, done SHALL be 0 in every cycle not specified above; mul_* outputs are don't-care when not in stage 1.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, index=0, pipeline valids=0, latched acc_mode=0.
REQ-026 During reset: busy=0, done=0, mem_rd_en=0, c_wr_en=0, all address/data outputs 0.
REQ-027 Reset mid-operation SHALL abort with no further reads or writes after deassertion and no done pulse; next start begins from index 0.

Verification
REQ-028 acc_mode=0, A=B=all 1, gamma ROM all 1 -> 128 writes, each c0=2, c1=2, addresses 0..127, done at cycle 131.
REQ-029 acc_mode=1, C preloaded 3328 everywhere, products c0=5, c1=0 -> written c0=4, c1=3328 (wrap and no-wrap paths).
REQ-030 Pulse start at cycles 0 and 50 -> single 128-write sequence; second start has no effect; start again cycle after done -> second full sequence.
REQ-031 Assert rst in cycle 60 for 1 cycle -> outputs zero immediately, no writes or done afterwards; subsequent start yields complete sequence from index 0.
REQ-032 Random A, B, gamma < Q, both modes -> all 128 results match software model (a0b0+a1b1*gamma mod Q, a0b1+a1b0 mod Q, plus C mod Q when accumulating).
REQ-033 Protocol checks throughout: c_wr_en exactly 2 cycles after each mem_rd_en, busy contiguous, done exactly one cycle per completed operation.
